// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG quantize/zigzag stage: zigzag order, luminance
// quantization table, its Q16 reciprocals, default widths and the FSM state type.
package jpeg_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RECIP_W = 17;
  localparam int unsigned FRAC_W  = 16;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Natural (row-major) index visited at each zigzag position.
  localparam logic [5:0] ZZ_ORDER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [7:0] QTAB_LUMA [0:63] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // round(65536 / QTAB_LUMA[n])
  localparam logic [RECIP_W-1:0] QRECIP_LUMA [0:63] = '{
    17'd4096, 17'd5958, 17'd6554, 17'd4096, 17'd2731, 17'd1638, 17'd1285, 17'd1074,
    17'd5461, 17'd5461, 17'd4681, 17'd3449, 17'd2521, 17'd1130, 17'd1092, 17'd1192,
    17'd4681, 17'd5041, 17'd4096, 17'd2731, 17'd1638, 17'd1150, 17'd950,  17'd1170,
    17'd4681, 17'd3855, 17'd2979, 17'd2260, 17'd1285, 17'd753,  17'd819,  17'd1057,
    17'd3641, 17'd2979, 17'd1771, 17'd1170, 17'd964,  17'd601,  17'd636,  17'd851,
    17'd2731, 17'd1872, 17'd1192, 17'd1024, 17'd809,  17'd630,  17'd580,  17'd712,
    17'd1337, 17'd1024, 17'd840,  17'd753,  17'd636,  17'd542,  17'd546,  17'd649,
    17'd910,  17'd712,  17'd690,  17'd669,  17'd585,  17'd655,  17'd636,  17'd662
  };

endpackage

// File: rtl/jpeg_quant_mul.sv
// Combinational sign-magnitude quantizer: q = sign(x) * round(|x| * r / 2^FracW),
// rounding half away from zero, saturated to the signed DataW range.
module jpeg_quant_mul #(
  parameter int unsigned DataW  = 8,
  parameter int unsigned RecipW = 17,
  parameter int unsigned FracW  = 16
) (
  input  logic signed [DataW-1:0]  x_i,
  input  logic        [RecipW-1:0] r_i,
  output logic signed [DataW-1:0]  q_o
);

  localparam int unsigned ProdW = DataW + 1 + RecipW;
  localparam logic [ProdW-1:0] Half   = ProdW'(1) << (FracW - 1);
  localparam logic [ProdW-1:0] PosMax = ProdW'((1 << (DataW - 1)) - 1);
  localparam logic [ProdW-1:0] NegMax = ProdW'(1 << (DataW - 1));

  logic             neg;
  logic [DataW:0]   x_ext;
  logic [DataW:0]   mag;
  logic [ProdW-1:0] prod;
  logic [ProdW-1:0] rnd;
  logic [ProdW-1:0] qmag;
  logic [DataW-1:0] qlow;

  always_comb begin
    neg   = x_i[DataW-1];
    // One extra bit so that |-2^(DataW-1)| is representable.
    x_ext = {x_i[DataW-1], x_i};
    mag   = neg ? -x_ext : x_ext;
    prod  = ProdW'(mag) * ProdW'(r_i);
    rnd   = prod + Half;
    qmag  = rnd >> FracW;
    qlow  = qmag[DataW-1:0];
    if (!neg) begin
      q_o = (qmag > PosMax) ? PosMax[DataW-1:0] : qlow;
    end else begin
      q_o = (qmag > NegMax) ? NegMax[DataW-1:0] : -qlow;
    end
  end

endmodule

// File: rtl/jpeg_quant_zigzag.sv
// Captures an 8x8 DCT block, quantizes it against the luminance table and streams
// it out in zigzag order. Define JPEG_QUANT_BYPASS_EN to add the quant_bypass input.
module jpeg_quant_zigzag
  import jpeg_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic signed [DATA_W-1:0] blk_data [0:63],
`ifdef JPEG_QUANT_BYPASS_EN
  input  logic                     quant_bypass,
`endif
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic signed [DATA_W-1:0] coef_data,
  output logic [5:0]               coef_idx,
  output logic                     coef_last
);

  state_e                   state_q;
  logic [5:0]               zz_q;
  logic signed [DATA_W-1:0] buf_q [0:63];
  logic [5:0]               nat_idx;
  logic signed [DATA_W-1:0] x_sel;
  logic signed [DATA_W-1:0] q_mul;
  logic signed [DATA_W-1:0] beat_d;
  logic                     accept;

  assign accept  = (state_q == StIdle) && blk_valid;
  assign nat_idx = ZZ_ORDER[zz_q];
  assign x_sel   = buf_q[nat_idx];

  jpeg_quant_mul #(
    .DataW (DATA_W),
    .RecipW(RECIP_W),
    .FracW (FRAC_W)
  ) u_mul (
    .x_i(x_sel),
    .r_i(QRECIP_LUMA[nat_idx]),
    .q_o(q_mul)
  );

  // Block buffer needs no reset: it is only read after a capture.
  always_ff @(posedge clock) begin
    if (accept) begin
      buf_q <= blk_data;
    end
  end

`ifdef JPEG_QUANT_BYPASS_EN
  logic bypass_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bypass_q <= 1'b0;
    end else if (accept) begin
      bypass_q <= quant_bypass;
    end
  end

  assign beat_d = bypass_q ? x_sel : q_mul;
`else
  assign beat_d = q_mul;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      blk_ready  <= 1'b1;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      zz_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (blk_valid) begin
            state_q   <= StRun;
            blk_ready <= 1'b0;
            zz_q      <= '0;
          end
        end
        StRun: begin
          // Beat register loads when empty or being consumed this cycle.
          if (!coef_valid || coef_ready) begin
            coef_valid <= 1'b1;
            coef_data  <= beat_d;
            coef_idx   <= zz_q;
            coef_last  <= (zz_q == 6'd63);
            zz_q       <= zz_q + 6'd1;
            if (zz_q == 6'd63) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (coef_ready) begin
            coef_valid <= 1'b0;
            blk_ready  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
